// File: rtl/shot_ctrl.sv
// shot_ctrl -- player shot controller sitting directly upstream of bfs.
//
// Accepts one shot at a time, reads the addressed board cell, marks it hit
// (10) or missed (11), and on a fresh hit launches bfs to decide whether the
// ship is sunk. Owns the board-memory port and hands it to bfs while a sink
// search runs. Counts hits and raises a sticky game_over once SHIP_CELLS
// hits have been recorded.
//
// Cell encoding: 00 water, 01 ship intact, 10 ship hit, 11 missed shot.
// Result codes : 00 miss, 01 hit, 10 sunk, 11 repeat/invalid.
//
// Optional feature: define SHOT_BOUNDS_CHECK_EN to reject shots outside the
// WIDTH x HEIGHT board with code 11 and no memory access.
//
// Ports:
//   clk_i, rstn_i                      clock, async active-low reset
//   shot_valid_i/shot_ready_o          shot handshake
//   shot_x_i, shot_y_i                 shot coordinates
//   result_valid_o, result_code_o      one-cycle result pulse and held code
//   game_over_o                        sticky until reset
//   bfs_start_o, bfs_x_o, bfs_y_o      sink-search request to bfs
//   bfs_sink_i, bfs_done_i             bfs result
//   bfs_mem_*_i                        bfs memory request (used in BFS_RUN)
//   mem_*_o                            board memory request
//   mem_rd_data_i, mem_ready_i         board memory response (shared with bfs)

module shot_ctrl #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned HEIGHT     = 6,
  parameter int unsigned SHIP_CELLS = 3
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  // Shot interface
  input  logic       shot_valid_i,
  output logic       shot_ready_o,
  input  logic [2:0] shot_x_i,
  input  logic [2:0] shot_y_i,
  output logic       result_valid_o,
  output logic [1:0] result_code_o,
  output logic       game_over_o,
  // bfs control
  output logic       bfs_start_o,
  output logic [2:0] bfs_x_o,
  output logic [2:0] bfs_y_o,
  input  logic       bfs_sink_i,
  input  logic       bfs_done_i,
  // bfs memory request
  input  logic [2:0] bfs_mem_addr_x_i,
  input  logic [2:0] bfs_mem_addr_y_i,
  input  logic [1:0] bfs_mem_wr_data_i,
  input  logic       bfs_mem_wr_en_i,
  input  logic       bfs_mem_in_valid_i,
  // Board memory port
  output logic [2:0] mem_addr_x_o,
  output logic [2:0] mem_addr_y_o,
  output logic [1:0] mem_wr_data_o,
  output logic       mem_wr_en_o,
  output logic       mem_in_valid_o,
  input  logic [1:0] mem_rd_data_i,
  input  logic       mem_ready_i
);

  localparam int unsigned   HitsW   = $clog2(SHIP_CELLS + 1);
  localparam logic [HitsW-1:0] HitsMax = HitsW'(SHIP_CELLS);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRd     = 3'd1;
  localparam logic [2:0] StRdWait = 3'd2;
  localparam logic [2:0] StWr     = 3'd3;
  localparam logic [2:0] StWrWait = 3'd4;
  localparam logic [2:0] StBfsRun = 3'd5;
  localparam logic [2:0] StResult = 3'd6;
  localparam logic [2:0] StOver   = 3'd7;

  localparam logic [1:0] CellWater  = 2'b00;
  localparam logic [1:0] CellShip   = 2'b01;
  localparam logic [1:0] CellHit    = 2'b10;
  localparam logic [1:0] CellMissed = 2'b11;

  localparam logic [1:0] CodeMiss   = 2'b00;
  localparam logic [1:0] CodeHit    = 2'b01;
  localparam logic [1:0] CodeSunk   = 2'b10;
  localparam logic [1:0] CodeRepeat = 2'b11;

  // Board dimensions are limited by the 3-bit coordinate ports.
  if (WIDTH < 1 || WIDTH > 8 || HEIGHT < 1 || HEIGHT > 8 || SHIP_CELLS < 1) begin : g_param_err
    $error("shot_ctrl: WIDTH/HEIGHT must be 1..8 and SHIP_CELLS at least 1");
  end

  logic [2:0]       state_q, state_d;
  logic [2:0]       x_q, x_d;
  logic [2:0]       y_q, y_d;
  logic [1:0]       wdata_q, wdata_d;
  logic             hit_q, hit_d;
  logic [HitsW-1:0] hits_q, hits_d;
  logic [1:0]       code_q, code_d;
  logic             over_q, over_d;
  // Keeps shot_ready low during reset and for the first cycle after it.
  logic             rdy_en_q;
  // High when the latched shot must not touch memory.
  logic             rd_skip;

`ifdef SHOT_BOUNDS_CHECK_EN
  logic oob_q, oob_d;
  assign rd_skip = oob_q;
`else
  assign rd_skip = 1'b0;
`endif

  assign shot_ready_o = (state_q == StIdle) && rdy_en_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    wdata_d = wdata_q;
    hit_d   = hit_q;
    hits_d  = hits_q;
    code_d  = code_q;
    over_d  = over_q;
`ifdef SHOT_BOUNDS_CHECK_EN
    oob_d   = oob_q;
`endif

    case (state_q)
      StIdle: begin
        if (shot_valid_i && shot_ready_o) begin
          x_d     = shot_x_i;
          y_d     = shot_y_i;
          state_d = StRd;
`ifdef SHOT_BOUNDS_CHECK_EN
          oob_d   = (32'(shot_x_i) >= WIDTH) || (32'(shot_y_i) >= HEIGHT);
`endif
        end
      end

      // The read strobe is issued combinationally from this state; an
      // out-of-bounds shot skips it and reports straight away.
      StRd: begin
        if (rd_skip) begin
          code_d  = CodeRepeat;
          state_d = StResult;
        end else begin
          state_d = StRdWait;
        end
      end

      StRdWait: begin
        if (mem_ready_i) begin
          unique case (mem_rd_data_i)
            CellWater: begin
              wdata_d = CellMissed;
              hit_d   = 1'b0;
              state_d = StWr;
            end
            CellShip: begin
              wdata_d = CellHit;
              hit_d   = 1'b1;
              if (hits_q != HitsMax) hits_d = hits_q + HitsW'(1);
              state_d = StWr;
            end
            default: begin
              code_d  = CodeRepeat;
              state_d = StResult;
            end
          endcase
        end
      end

      StWr: state_d = StWrWait;

      StWrWait: begin
        if (mem_ready_i) begin
          if (hit_q) begin
            state_d = StBfsRun;
          end else begin
            code_d  = CodeMiss;
            state_d = StResult;
          end
        end
      end

      StBfsRun: begin
        if (bfs_done_i) begin
          code_d  = bfs_sink_i ? CodeSunk : CodeHit;
          state_d = StResult;
        end
      end

      StResult: state_d = over_q ? StOver : StIdle;

      StOver: state_d = StOver;

      default: state_d = StIdle;
    endcase

    // game_over is raised on the same edge that enters RESULT so that it
    // coincides with result_valid of the final sinking shot.
    if (state_d == StResult && state_q != StResult && hits_q == HitsMax) begin
      over_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      wdata_q  <= '0;
      hit_q    <= 1'b0;
      hits_q   <= '0;
      code_q   <= '0;
      over_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      wdata_q  <= wdata_d;
      hit_q    <= hit_d;
      hits_q   <= hits_d;
      code_q   <= code_d;
      over_q   <= over_d;
      rdy_en_q <= 1'b1;
    end
  end

`ifdef SHOT_BOUNDS_CHECK_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      oob_q <= 1'b0;
    end else begin
      oob_q <= oob_d;
    end
  end
`endif

  // Outputs decoded from state so reset clears them asynchronously.
  assign result_valid_o = (state_q == StResult);
  assign result_code_o  = code_q;
  assign game_over_o    = over_q;
  assign bfs_start_o    = (state_q == StBfsRun);
  assign bfs_x_o        = x_q;
  assign bfs_y_o        = y_q;

  // Memory port mux: bfs owns the port only while its search runs.
  always_comb begin
    if (state_q == StBfsRun) begin
      mem_addr_x_o   = bfs_mem_addr_x_i;
      mem_addr_y_o   = bfs_mem_addr_y_i;
      mem_wr_data_o  = bfs_mem_wr_data_i;
      mem_wr_en_o    = bfs_mem_wr_en_i;
      mem_in_valid_o = bfs_mem_in_valid_i;
    end else begin
      mem_addr_x_o   = x_q;
      mem_addr_y_o   = y_q;
      mem_wr_data_o  = wdata_q;
      mem_wr_en_o    = (state_q == StWr);
      mem_in_valid_o = ((state_q == StRd) && !rd_skip) || (state_q == StWr);
    end
  end

endmodule

// File: tb/tb_shot_ctrl.sv
// Directed self-checking bench for shot_ctrl on a 6x6 board with ships at
// (1,1), (2,1) and (1,2). A behavioural board memory answers one cycle after
// each strobe; bfs responses are driven from the directed steps.
// Define SHOT_BOUNDS_CHECK_EN to also exercise the out-of-bounds path.

module tb_shot_ctrl;

  logic       clk;
  logic       rstn;
  logic       shot_valid;
  logic       shot_ready;
  logic [2:0] shot_x, shot_y;
  logic       result_valid;
  logic [1:0] result_code;
  logic       game_over;
  logic       bfs_start;
  logic [2:0] bfs_x, bfs_y;
  logic       bfs_sink, bfs_done;
  logic [2:0] bfs_mem_addr_x, bfs_mem_addr_y;
  logic [1:0] bfs_mem_wr_data;
  logic       bfs_mem_wr_en, bfs_mem_in_valid;
  logic [2:0] mem_addr_x, mem_addr_y;
  logic [1:0] mem_wr_data;
  logic       mem_wr_en, mem_in_valid;
  logic [1:0] mem_rd_data;
  logic       mem_ready;

  int checks   = 0;
  int failures = 0;

  shot_ctrl #(
    .WIDTH     (6),
    .HEIGHT    (6),
    .SHIP_CELLS(3)
  ) dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .shot_valid_i      (shot_valid),
    .shot_ready_o      (shot_ready),
    .shot_x_i          (shot_x),
    .shot_y_i          (shot_y),
    .result_valid_o    (result_valid),
    .result_code_o     (result_code),
    .game_over_o       (game_over),
    .bfs_start_o       (bfs_start),
    .bfs_x_o           (bfs_x),
    .bfs_y_o           (bfs_y),
    .bfs_sink_i        (bfs_sink),
    .bfs_done_i        (bfs_done),
    .bfs_mem_addr_x_i  (bfs_mem_addr_x),
    .bfs_mem_addr_y_i  (bfs_mem_addr_y),
    .bfs_mem_wr_data_i (bfs_mem_wr_data),
    .bfs_mem_wr_en_i   (bfs_mem_wr_en),
    .bfs_mem_in_valid_i(bfs_mem_in_valid),
    .mem_addr_x_o      (mem_addr_x),
    .mem_addr_y_o      (mem_addr_y),
    .mem_wr_data_o     (mem_wr_data),
    .mem_wr_en_o       (mem_wr_en),
    .mem_in_valid_o    (mem_in_valid),
    .mem_rd_data_i     (mem_rd_data),
    .mem_ready_i       (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board memory model; shot-originated strobes are counted separately from
  // those made while bfs owns the port.
  logic [1:0] board [0:63];
  logic       restore;
  int         mem_idx;
  int         rd_cnt, wr_cnt, last_wr_idx;
  logic [1:0] last_wr_data;

  assign mem_idx = int'(mem_addr_y) * 6 + int'(mem_addr_x);

  always @(posedge clk) begin
    mem_ready <= mem_in_valid;
    if (restore) begin
      for (int i = 0; i < 64; i++) board[i] <= 2'b00;
      board[7]  <= 2'b01;
      board[8]  <= 2'b01;
      board[13] <= 2'b01;
      rd_cnt    <= 0;
      wr_cnt    <= 0;
    end else if (mem_in_valid) begin
      mem_rd_data <= board[mem_idx];
      if (mem_wr_en) board[mem_idx] <= mem_wr_data;
      if (!bfs_start) begin
        if (mem_wr_en) begin
          wr_cnt       <= wr_cnt + 1;
          last_wr_idx  <= mem_idx;
          last_wr_data <= mem_wr_data;
        end else begin
          rd_cnt <= rd_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one shot and waits for the result; returns the cycle (counted
  // from the accepting edge) in which result_valid was seen, 0 on timeout.
  task automatic shoot(input logic [2:0] x, input logic [2:0] y, input int bfs_lat,
                       input logic sink, output int cyc, output logic [1:0] code);
    int bcnt;
    bcnt = 0;
    cyc  = 0;
    code = 2'bxx;
    @(posedge clk); #1;
    shot_x     = x;
    shot_y     = y;
    shot_valid = 1'b1;
    @(posedge clk); #1;
    shot_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (bfs_start) begin
        bcnt++;
        bfs_mem_in_valid = 1'b1;
        bfs_done         = (bcnt == bfs_lat);
        bfs_sink         = sink;
        #1;
        if (bcnt == 1) begin
          check("bfs_xy", {26'd0, bfs_x, bfs_y}, {26'd0, x, y});
          check("mux_bfs", {22'd0, mem_addr_x, mem_addr_y, mem_wr_data, mem_wr_en,
                            mem_in_valid}, {22'd0, 3'd5, 3'd4, 2'b10, 1'b1, 1'b1});
        end
      end else begin
        bfs_done         = 1'b0;
        bfs_mem_in_valid = 1'b0;
      end
      if (result_valid) begin
        cyc  = k;
        code = result_code;
        break;
      end
      @(posedge clk); #1;
    end
    bfs_done         = 1'b0;
    bfs_mem_in_valid = 1'b0;
  endtask

  initial begin
    int         cyc, rd0, wr0;
    logic [1:0] code;

    rstn             = 1'b0;
    restore          = 1'b1;
    shot_valid       = 1'b0;
    shot_x           = '0;
    shot_y           = '0;
    bfs_sink         = 1'b0;
    bfs_done         = 1'b0;
    bfs_mem_addr_x   = 3'd5;
    bfs_mem_addr_y   = 3'd4;
    bfs_mem_wr_data  = 2'b10;
    bfs_mem_wr_en    = 1'b1;
    bfs_mem_in_valid = 1'b0;

    #1;
    check("reset_outs", {26'd0, shot_ready, result_valid, game_over, bfs_start,
                         mem_in_valid, mem_wr_en}, 32'd0);
    check("reset_code", {30'd0, result_code}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    restore = 1'b0;
    rstn    = 1'b1;
    @(posedge clk); #1;
    check("ready_idle", {31'd0, shot_ready}, 32'd1);

    // Miss on water
    rd0 = rd_cnt; wr0 = wr_cnt;
    shoot(3'd0, 3'd0, 0, 1'b0, cyc, code);
    check("miss_cycle", cyc, 5);
    check("miss_code", {30'd0, code}, {30'd0, 2'b00});
    check("miss_strobes", (rd_cnt - rd0) * 16 + (wr_cnt - wr0), 17);
    check("miss_write", last_wr_idx * 4 + int'(last_wr_data), 3);

    // Repeat shot: read only
    rd0 = rd_cnt; wr0 = wr_cnt;
    shoot(3'd0, 3'd0, 0, 1'b0, cyc, code);
    check("rep_cycle", cyc, 3);
    check("rep_code", {30'd0, code}, {30'd0, 2'b11});
    check("rep_strobes", (rd_cnt - rd0) * 16 + (wr_cnt - wr0), 16);

`ifdef SHOT_BOUNDS_CHECK_EN
    rd0 = rd_cnt; wr0 = wr_cnt;
    shoot(3'd6, 3'd0, 0, 1'b0, cyc, code);
    check("oob_cycle", cyc, 2);
    check("oob_code", {30'd0, code}, {30'd0, 2'b11});
    shoot(3'd0, 3'd6, 0, 1'b0, cyc, code);
    check("oob_y_cycle", cyc, 2);
    check("oob_strobes", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
`endif

    // First hit, not sunk
    shoot(3'd1, 3'd1, 2, 1'b0, cyc, code);
    check("hit1_cycle", cyc, 7);
    check("hit1_code", {30'd0, code}, {30'd0, 2'b01});
    check("hit1_cell", {30'd0, board[7]}, {30'd0, 2'b10});
    check("hit1_mux_off", {31'd0, mem_in_valid}, 32'd0);
    check("hit1_over", {31'd0, game_over}, 32'd0);

    shoot(3'd2, 3'd1, 3, 1'b0, cyc, code);
    check("hit2_cycle", cyc, 8);
    check("hit2_code", {30'd0, code}, {30'd0, 2'b01});
    check("hit2_over", {31'd0, game_over}, 32'd0);

    // Final sinking shot
    shoot(3'd1, 3'd2, 1, 1'b1, cyc, code);
    check("sunk_cycle", cyc, 6);
    check("sunk_code", {30'd0, code}, {30'd0, 2'b10});
    check("sunk_over", {31'd0, game_over}, 32'd1);
    @(posedge clk); #1;
    check("code_hold", {29'd0, result_valid, result_code}, {29'd0, 1'b0, 2'b10});

    // Game over: shots are ignored
    rd0 = rd_cnt;
    shot_x     = 3'd3;
    shot_y     = 3'd3;
    shot_valid = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("over_ready", {30'd0, shot_ready, game_over}, {30'd0, 1'b0, 1'b1});
    end
    shot_valid = 1'b0;
    check("over_no_rd", rd_cnt - rd0, 0);

    // Asynchronous reset clears game_over
    rstn = 1'b0;
    #1;
    check("rst_over", {30'd0, game_over, shot_ready}, 32'd0);
    restore = 1'b1;
    @(posedge clk); #1;
    restore = 1'b0;
    rstn    = 1'b1;
    @(posedge clk); #1;

    // Reset while bfs is running
    shot_x     = 3'd1;
    shot_y     = 3'd1;
    shot_valid = 1'b1;
    @(posedge clk); #1;
    shot_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bfs_run", {31'd0, bfs_start}, 32'd1);
    rstn = 1'b0;
    #1;
    check("bfs_abort", {29'd0, bfs_start, result_valid, game_over}, 32'd0);
    restore = 1'b1;
    @(posedge clk); #1;
    restore = 1'b0;
    rstn    = 1'b1;
    @(posedge clk); #1;

    // Fresh game: the hit counter must have restarted from zero
    shoot(3'd1, 3'd1, 1, 1'b0, cyc, code);
    check("g2_hit1", {29'd0, game_over, code}, {29'd0, 1'b0, 2'b01});
    shoot(3'd2, 3'd1, 1, 1'b0, cyc, code);
    check("g2_hit2", {29'd0, game_over, code}, {29'd0, 1'b0, 2'b01});
    shoot(3'd1, 3'd2, 1, 1'b1, cyc, code);
    check("g2_sunk_cycle", cyc, 6);
    check("g2_sunk", {29'd0, game_over, code}, {29'd0, 1'b1, 2'b10});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
